q_pipe_sink: RTL and testbench
==============================

Name: q_pipe_sink

Overview:
- Synchronous drain end of a Q-flop pipeline.
- Acts as the four-phase responder on the last stage's req/data bundle and returns ack.
- Buffers captured words in a small FIFO and presents them to a clocked consumer over valid/ready.
- Sits at the boundary where an asynchronous Q-flop chain hands results into the synchronous system.

Parameters:
WIDTH, 8, data width of the bundled-data word.
DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req  input  1  four-phase request from the last Q-flop stage (asynchronous to clk).
data  input  WIDTH  bundled data; stable whenever req=1.
ack  output  1  four-phase acknowledge to the pipeline (registered).
out_data  output  WIDTH  FIFO head word.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head this cycle.
count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: synchronous, active-high; takes effect on the rising edge where rst=1.
  - ack=0, state IDLE, FIFO empty (count=0, out_valid=0), pointers 0, synchronizer flops 0.
  - out_data is don't-care while out_valid=0.
- req_s: internal request used by the FSM; source depends on the optional feature below.
- FSM, two states, with ack registered equal to (state==ACKED):
  - IDLE: if req_s=1 and count<DEPTH, then write data to the tail, increment the tail, set ack<=1, go to ACKED.
  - IDLE, otherwise: stay. If req_s=1 but the FIFO is full, ack stays 0 and the pipeline stalls. No data is dropped.
  - ACKED: if req_s=0, set ack<=0 and go to IDLE. Otherwise hold ack=1.
  - Exactly one FIFO write per four-phase handshake. A long req-high phase never causes a second write.
- Pop: when out_valid=1 and out_ready=1, increment the head. out_ready with an empty FIFO is ignored and count does not underflow.
- Simultaneous push and pop: count is unchanged, both pointers advance.
- Full with pop in the same cycle: the push decision uses the pre-edge count. So a full FIFO does not accept a push on the same edge as a pop; the push happens on the next edge.
- Pointers: clog2(DEPTH) bits, wrap modulo DEPTH. count is a separate up/down counter ranging 0..DEPTH.
- out_data: combinational read of the head entry. out_valid = (count!=0).
- Latency: ack and out_valid (from empty) rise on the same edge, one edge after req_s is first seen high. The consumer may pop on the next cycle.
- Reset mid-handshake:
  - ack drops to 0 immediately.
  - Buffered words are discarded.
  - If req is still high after reset, it is treated as a new request and captured again. Upstream must tolerate this duplicate; this is documented, not an error.

Optional Feature:
QSINK_SYNC_EN
- Defined: req passes through a two-flop synchronizer (reset to 0), and req_s is the second flop.
  - If edge N is the first to sample req=1, ack rises after edge N+2.
  - Release follows the same timing: ack falls two edges after req=0 is first sampled.
- Undefined: req_s = req directly. Used when req is already generated in the clk domain, e.g. a clocked Q-stage model.
  - If edge N is the first to sample req=1, ack rises after edge N.
- data is always sampled raw. With the synchronizer, bundled-data stability is guaranteed by upstream holding data until ack.

Test Plan:
- Reset then single handshake (SYNC_EN on): rst=1 for 2 cycles; req=1, data=8'hA5. Required: ack=1 and out_valid=1 two edges after req is first sampled, out_data=8'hA5, count=1. Then req=0: ack=0 two edges later.
- Fill with the consumer stalled: out_ready=0, four handshakes with data 1,2,3,4 (DEPTH=4). Required: count=4. On a fifth request with data 5, ack stays 0 indefinitely.
- Drain after full: raise out_ready. Required: first pop gives out_data=1 and count=3. The pending fifth request is captured on the following edge with ack=1. Pop order is 1,2,3,4,5, then out_valid=0.
- Concurrent push/pop at count=2 with out_ready=1 on the capture edge. Required: count stays 2, and data order is preserved across pointer wrap. Run 10 handshakes and confirm every word emerges in order.
- Long req-high phase: hold req=1 for 20 cycles. Required: exactly one write (count increments by 1) and ack remains 1 throughout.
- Reset mid-handshake: with ack=1, count=2 and req=1, assert rst for 1 cycle. Required: ack=0, count=0, out_valid=0 next edge. With req still 1 after reset, a new capture occurs (count=1, ack=1).

Source files
------------

// File: rtl/q_pipe_sink.sv
// Synchronous drain end of a Q-flop pipeline: four-phase responder on req/ack feeding a valid/ready FIFO.
// Define QSINK_SYNC_EN to pass req through a two-flop synchronizer; otherwise req is used directly.
module q_pipe_sink #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [WIDTH-1:0]         data,
  output logic                     ack,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, ACKED} state_t;

  state_t            state, state_nxt;
  logic              req_s;
  logic              push, pop;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

`ifdef QSINK_SYNC_EN
  logic req_p0, req_p1;

  // stage p0/p1: metastability filter for the asynchronous request
  always_ff @(posedge clk) begin
    if (rst) begin
      req_p0 <= 1'b0;
      req_p1 <= 1'b0;
    end else begin
      req_p0 <= req;
      req_p1 <= req_p0;
    end
  end

  assign req_s = req_p1;
`else
  assign req_s = req;
`endif

  // One write per handshake: only IDLE can push, and ACKED waits for req to fall.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (req_s && (count < FULL)) begin
          push      = 1'b1;
          state_nxt = ACKED;
        end
      end
      ACKED: begin
        if (!req_s) state_nxt = IDLE;
      end
    endcase
  end

  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign ack       = (state == ACKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

endmodule

// File: tb/tb_q_pipe_sink.sv
// Bench for q_pipe_sink: directed handshake scenarios plus randomized traffic,
// every cycle compared against a queue-based reference model.
module tb_q_pipe_sink;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef QSINK_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic                   clk, rst, req, ack, out_valid, out_ready;
  logic [WIDTH-1:0]       data, out_data;
  logic [$clog2(DEPTH):0] count;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;
  bit rand_rdy = 0;

  // reference model state
  bit   m_acked;
  int   m_q[$];
  bit   h1, h2;

  q_pipe_sink #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change only 1 time unit after a falling edge, so at the falling edge
  // they still hold the values the preceding rising edge sampled.
  always @(negedge clk) begin
    bit rs, push, pop;
    if (rst) begin
      m_acked = 0;
      m_q.delete();
      h1 = 0;
      h2 = 0;
    end else begin
      rs   = (L == 2) ? h2 : req;
      h2   = h1;
      h1   = req;
      push = !m_acked && rs && (m_q.size() < DEPTH);
      pop  = (m_q.size() > 0) && out_ready;
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(int'(data));
      if (push) m_acked = 1;
      else if (m_acked && !rs) m_acked = 0;
    end
    if (chk_en) begin
      check("model_ack", ack, m_acked);
      check("model_valid", out_valid, m_q.size() != 0);
      check("model_count", count, m_q.size());
      if (m_q.size() != 0) check("model_data", out_data, m_q[0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic wait_ack(input logic v);
    bit seen = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (ack === v) seen = 1;
      else cyc(1);
    end
    if (!seen) check("ack_timeout", ack, v);
  endtask

  task automatic handshake(input logic [WIDTH-1:0] d);
    req  = 1;
    data = d;
    wait_ack(1);
    req = 0;
    wait_ack(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; rst = 1; req = 0; data = '0; out_ready = 0;
    cyc(2);
    chk_en = 1;
    check("rst_ack", ack, 0);
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    rst = 0;

    // single handshake with exact latency
    req = 1; data = 8'hA5;
    cyc(L);
    check("hs_ack_early", ack, 0);
    cyc(1);
    check("hs_ack", ack, 1);
    check("hs_valid", out_valid, 1);
    check("hs_data", out_data, 8'hA5);
    check("hs_count", count, 1);
    req = 0;
    cyc(L);
    check("hs_ack_hold", ack, 1);
    cyc(1);
    check("hs_ack_fall", ack, 0);
    out_ready = 1;
    cyc(1);
    out_ready = 0;
    check("hs_popped", out_valid, 0);

    // fill with stalled consumer, fifth request stalls
    for (int i = 1; i <= 4; i++) handshake(WIDTH'(i));
    check("fill_count", count, 4);
    req = 1; data = 8'd5;
    cyc(10);
    check("full_ack", ack, 0);
    check("full_count", count, 4);

    // drain: pop frees a slot, pending word captured on the following edge
    check("drain_d1", out_data, 1);
    out_ready = 1;
    cyc(1);
    check("drain_count", count, 3);
    check("drain_ack0", ack, 0);
    check("drain_d2", out_data, 2);
    cyc(1);
    check("drain_ack1", ack, 1);
    check("drain_count2", count, 3);
    check("drain_d3", out_data, 3);
    req = 0;
    cyc(1);
    check("drain_d4", out_data, 4);
    cyc(1);
    check("drain_d5", out_data, 5);
    cyc(1);
    check("drain_empty", out_valid, 0);
    out_ready = 0;
    wait_ack(0);

    // push and pop on the same edge at count=2
    handshake(8'h10);
    handshake(8'h11);
    check("pp_pre_count", count, 2);
    req = 1; data = 8'h12;
    cyc(L);
    out_ready = 1;
    cyc(1);
    check("pp_count", count, 2);
    check("pp_ack", ack, 1);
    check("pp_head", out_data, 8'h11);
    out_ready = 0;
    req = 0;
    wait_ack(0);

    // randomized traffic across pointer wrap; order checked by the model
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      handshake(WIDTH'($urandom_range(0, 255)));
      cyc($urandom_range(0, 3));
    end
    rand_rdy = 0;
    out_ready = 1;
    cyc(DEPTH + 1);
    check("rand_drained", out_valid, 0);
    out_ready = 0;

    // long req-high phase: exactly one write
    handshake(8'h20);
    req = 1; data = 8'h21;
    cyc(20);
    check("long_ack", ack, 1);
    check("long_count", count, 2);

    // reset mid-handshake, req still high afterwards
    rst = 1;
    cyc(1);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    rst = 0;
    cyc(1 + L);
    check("recap_ack", ack, 1);
    check("recap_count", count, 1);
    check("recap_data", out_data, 8'h21);
    req = 0;
    wait_ack(0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
